// File: rtl/ring_link_rx.sv
// ring_link_rx: ring link receive FIFO with on/off backpressure, valid/ready output and statistics.
module ring_link_rx #(
  parameter int PACKET_SIZE  = 49,
  parameter int BUFFER_SIZE  = 4,
  parameter int OFF_SLACK    = 2,
  parameter int ON_THRESHOLD = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PACKET_SIZE-1:0]           link_in,
  output logic                             backpressure_wr,
  output logic [PACKET_SIZE-1:0]           out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] occupancy,
  output logic [63:0]                      rx_count,
  output logic [15:0]                      drop_count,
  output logic                             overflow_err
);
  localparam int AW = BUFFER_SIZE > 1 ? $clog2(BUFFER_SIZE) : 1;
  localparam int OW = $clog2(BUFFER_SIZE + 1);
  localparam logic [AW-1:0] LAST    = AW'(BUFFER_SIZE - 1);
  localparam logic [OW-1:0] FULL    = OW'(BUFFER_SIZE);
  localparam logic [OW-1:0] OFF_LVL = OW'(BUFFER_SIZE - OFF_SLACK);
  localparam logic [OW-1:0] ON_LVL  = OW'(ON_THRESHOLD);

  typedef enum logic {ST_ON, ST_OFF} state_t;

  logic [PACKET_SIZE-1:0] mem [BUFFER_SIZE];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [OW-1:0]          occ_next;
  logic                   push, pop, full, accept, drop;
  state_t                 state;

  assign push      = link_in[PACKET_SIZE-1];
  assign out_valid = occupancy != '0;
  assign full      = occupancy == FULL;
  assign pop       = out_valid & out_ready;
  assign accept    = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign occ_next  = occupancy + OW'(accept) - OW'(pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign backpressure_wr = state == ST_OFF;

  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= link_in;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      rx_count     <= '0;
      drop_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      occupancy <= occ_next;
      if (accept) begin
        wr_ptr   <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
        rx_count <= rx_count + 64'd1;
      end
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      if (drop) begin
        overflow_err <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end

  // Thresholds are applied to post-update occupancy so OFF rises on the crossing edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_ON;
    else if (state == ST_ON && occ_next >= OFF_LVL) state <= ST_OFF;
    else if (state == ST_OFF && occ_next <= ON_LVL) state <= ST_ON;
endmodule

// File: tb/tb_ring_link_rx.sv
// tb_ring_link_rx: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_ring_link_rx;
  logic        clk = 1'b0, rst_n = 1'b1, out_ready = 1'b0, backpressure_wr, out_valid, overflow_err;
  logic [48:0] link_in = '0, out_data;
  logic [2:0]  occupancy;
  logic [63:0] rx_count;
  logic [15:0] drop_count;
  logic [48:0] q [$];
  int          pass_cnt = 0, total_cnt = 0;

  ring_link_rx dut (
    .clk(clk), .rst_n(rst_n), .link_in(link_in), .backpressure_wr(backpressure_wr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy),
    .rx_count(rx_count), .drop_count(drop_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [48:0] mk(input logic [15:0] ts, input logic [15:0] src, input logic [15:0] dst);
    return {1'b1, ts, src, dst};
  endfunction

  task automatic step(input logic [48:0] p, input logic r);
    link_in = p;
    out_ready = r;
    @(posedge clk);
    #1;
    link_in = '0;
  endtask

  task automatic send(input logic [48:0] p, input logic r, input bit acc);
    if (acc) q.push_back(p);
    step(p, r);
  endtask

  task automatic chk_state(input string name, input int occ, input logic bp);
    chk({name, "_occ"}, 64'(occupancy), 64'(occ));
    chk({name, "_bp"}, 64'(backpressure_wr), 64'(bp));
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 64'(out_data), 64'h0);
      else chk("sb_data", 64'(out_data), 64'(q.pop_front()));
    end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [48:0] p1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_rx", rx_count, 0);
    chk("rst_drop", 64'(drop_count), 0);
    chk("rst_ovf", 64'(overflow_err), 0);
    chk_state("rst", 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single packet streams straight through
    p1 = mk(16'h0010, 16'd3, 16'd1);
    send(p1, 1'b1, 1);
    chk("t1_valid", 64'(out_valid), 1);
    chk("t1_data", 64'(out_data), 64'(p1));
    chk("t1_rx", rx_count, 1);
    chk_state("t1a", 1, 1'b0);
    step('0, 1'b1);
    chk_state("t1b", 0, 1'b0);

    // OFF raised on the edge occupancy reaches 2
    send(mk(16'h0020, 16'd2, 16'd5), 1'b0, 1);
    chk_state("t2a", 1, 1'b0);
    send(mk(16'h0021, 16'd2, 16'd6), 1'b0, 1);
    chk_state("t2b", 2, 1'b1);

    // in-flight slack absorbed, then OFF released at occupancy 1
    send(mk(16'h0022, 16'd2, 16'd7), 1'b0, 1);
    chk_state("t3a", 3, 1'b1);
    send(mk(16'h0023, 16'd2, 16'd8), 1'b0, 1);
    chk_state("t3b", 4, 1'b1);
    chk("t3_drop", 64'(drop_count), 0);
    step('0, 1'b1);
    chk_state("t3c", 3, 1'b1);
    step('0, 1'b1);
    chk_state("t3d", 2, 1'b1);
    step('0, 1'b1);
    chk_state("t3e", 1, 1'b0);
    step('0, 1'b1);
    chk_state("t3f", 0, 1'b0);

    // overflow drops the extra packet only
    for (int i = 0; i < 4; i++) send(mk(16'h0030 + 16'(i), 16'd4, 16'(i)), 1'b0, 1);
    chk("t4_rx_full", rx_count, 9);
    send(mk(16'hDEAD, 16'd9, 16'd9), 1'b0, 0);
    chk("t4_drop", 64'(drop_count), 1);
    chk("t4_ovf", 64'(overflow_err), 1);
    chk("t4_rx", rx_count, 9);
    chk("t4_head", 64'(out_data), 64'(mk(16'h0030, 16'd4, 16'd0)));
    chk_state("t4", 4, 1'b1);
    for (int i = 0; i < 4; i++) step('0, 1'b1);
    chk_state("t4_drained", 0, 1'b0);

    // full FIFO with simultaneous push/pop, streaming across pointer wrap
    for (int i = 0; i < 4; i++) send(mk(16'h0040 + 16'(i), 16'd5, 16'(i)), 1'b0, 1);
    send(mk(16'h0044, 16'd5, 16'd4), 1'b1, 1);
    chk_state("t5a", 4, 1'b1);
    chk("t5_drop", 64'(drop_count), 1);
    for (int i = 0; i < 10; i++) send(mk(16'h0050 + 16'(i), 16'd6, 16'(i)), 1'b1, 1);
    chk_state("t5b", 4, 1'b1);
    chk("t5_drop2", 64'(drop_count), 1);
    chk("t5_rx", rx_count, 24);
    for (int i = 0; i < 4; i++) step('0, 1'b1);
    chk_state("t5c", 0, 1'b0);
    chk("t5_sb_empty", 64'(q.size()), 0);

    // asynchronous reset mid-cycle discards buffered packets
    for (int i = 0; i < 3; i++) send(mk(16'h0060 + 16'(i), 16'd7, 16'(i)), 1'b0, 1);
    chk_state("t6a", 3, 1'b1);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("t6_valid", 64'(out_valid), 0);
    chk("t6_data", 64'(out_data), 0);
    chk("t6_rx", rx_count, 0);
    chk("t6_drop", 64'(drop_count), 0);
    chk("t6_ovf", 64'(overflow_err), 0);
    chk_state("t6b", 0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(mk(16'h0070, 16'd8, 16'd1), 1'b1, 1);
    chk("t6_rx1", rx_count, 1);
    chk("t6_valid1", 64'(out_valid), 1);
    step('0, 1'b1);
    step('0, 1'b1);
    chk_state("t6c", 0, 1'b0);
    chk("final_sb_empty", 64'(q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
